// File: rtl/axi_sram_slave.sv
// axi_sram_slave
//   AXI4 responder backed by an internal word-addressed SRAM. Read and write
//   channels are independent, each holding one outstanding transaction.
//   FIXED and INCR bursts of up to 256 beats are served. WRAP and the
//   reserved burst type are answered with SLVERR on every beat, with the
//   address held fixed and, for writes, no memory update.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   ar*  (in) / arready (out)  read address channel
//   r*   (out) / rready (in)   read data channel
//   aw*  (in) / awready (out)  write address channel
//   w*   (in) / wready (out)   write data channel
//   b*   (out) / bready (in)   write response channel
//   All outputs come straight from registers and reset to 0.
module axi_sram_slave #(
    parameter int    ADDR_BITS = 16,
    parameter string INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);
    localparam int         WORDS       = 1 << (ADDR_BITS - 2);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    logic [31:0] mem [WORDS];

    // INCR steps by the beat size; every other burst type holds the address
    // (unsupported types are flagged separately through burst[1]).
    function automatic logic [31:0] next_addr(input logic [31:0] a,
                                              input logic [2:0]  size,
                                              input logic [1:0]  burst);
        return (burst == BURST_INCR) ? a + (32'd1 << size) : a;
    endfunction

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    r_state_t    r_state, r_state_n;
    logic [31:0] r_addr, r_addr_n, r_addr_adv;
    logic [7:0]  r_cnt, r_cnt_n, r_len, r_len_n;
    logic [2:0]  r_size, r_size_n;
    logic [1:0]  r_burst, r_burst_n;
    logic        arready_n, rvalid_n, rlast_n;
    logic [3:0]  rid_n;
    logic [31:0] rdata_n;
    logic [1:0]  rresp_n;

    assign r_addr_adv = next_addr(r_addr, r_size, r_burst);

    always_comb begin
        r_state_n = r_state;
        r_addr_n  = r_addr;
        r_cnt_n   = r_cnt;
        r_len_n   = r_len;
        r_size_n  = r_size;
        r_burst_n = r_burst;
        arready_n = arready;
        rvalid_n  = rvalid;
        rlast_n   = rlast;
        rid_n     = rid;
        rdata_n   = rdata;
        rresp_n   = rresp;
        case (r_state)
            R_IDLE: begin
                arready_n = 1'b1;
                if (arvalid && arready) begin
                    r_addr_n  = araddr;
                    r_len_n   = arlen;
                    r_size_n  = arsize;
                    r_burst_n = arburst;
                    r_cnt_n   = 8'd0;
                    rid_n     = arid;
                    rresp_n   = arburst[1] ? RESP_SLVERR : RESP_OKAY;
                    // Sampled before any same-edge write lands: read-before-write.
                    rdata_n   = mem[araddr[ADDR_BITS-1:2]];
                    rlast_n   = (arlen == 8'd0);
                    rvalid_n  = 1'b1;
                    arready_n = 1'b0;
                    r_state_n = R_DATA;
                end
            end
            R_DATA: begin
                if (rvalid && rready) begin
                    if (rlast) begin
                        rvalid_n  = 1'b0;
                        rlast_n   = 1'b0;
                        arready_n = 1'b1;
                        r_state_n = R_IDLE;
                    end else begin
                        // Prefetch the next beat so beats stream without bubbles.
                        r_cnt_n  = r_cnt + 8'd1;
                        r_addr_n = r_addr_adv;
                        rdata_n  = mem[r_addr_adv[ADDR_BITS-1:2]];
                        rlast_n  = ((r_cnt + 8'd1) == r_len);
                    end
                end
            end
            default: r_state_n = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= R_IDLE;
            r_addr  <= '0;
            r_cnt   <= '0;
            r_len   <= '0;
            r_size  <= '0;
            r_burst <= '0;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rlast   <= 1'b0;
            rid     <= '0;
            rdata   <= '0;
            rresp   <= '0;
        end else begin
            r_state <= r_state_n;
            r_addr  <= r_addr_n;
            r_cnt   <= r_cnt_n;
            r_len   <= r_len_n;
            r_size  <= r_size_n;
            r_burst <= r_burst_n;
            arready <= arready_n;
            rvalid  <= rvalid_n;
            rlast   <= rlast_n;
            rid     <= rid_n;
            rdata   <= rdata_n;
            rresp   <= rresp_n;
        end
    end

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    w_state_t    w_state, w_state_n;
    logic [31:0] w_addr, w_addr_n;
    logic [7:0]  w_cnt, w_cnt_n, w_len, w_len_n;
    logic [2:0]  w_size, w_size_n;
    logic [1:0]  w_burst, w_burst_n;
    logic [3:0]  w_id, w_id_n;
    logic        w_err, w_err_n;      // sticky: bad burst type or wlast mismatch
    logic        awready_n, wready_n, bvalid_n;
    logic [3:0]  bid_n;
    logic [1:0]  bresp_n;
    logic        w_fire, w_is_last, mem_we;

    assign w_fire    = (w_state == W_DATA) && wvalid && wready;
    assign w_is_last = (w_cnt == w_len);
    assign mem_we    = w_fire && !w_burst[1];

    always_comb begin
        w_state_n = w_state;
        w_addr_n  = w_addr;
        w_cnt_n   = w_cnt;
        w_len_n   = w_len;
        w_size_n  = w_size;
        w_burst_n = w_burst;
        w_id_n    = w_id;
        w_err_n   = w_err;
        awready_n = awready;
        wready_n  = wready;
        bvalid_n  = bvalid;
        bid_n     = bid;
        bresp_n   = bresp;
        case (w_state)
            W_IDLE: begin
                awready_n = 1'b1;
                if (awvalid && awready) begin
                    w_addr_n  = awaddr;
                    w_len_n   = awlen;
                    w_size_n  = awsize;
                    w_burst_n = awburst;
                    w_id_n    = awid;
                    w_cnt_n   = 8'd0;
                    w_err_n   = awburst[1];
                    awready_n = 1'b0;
                    wready_n  = 1'b1;
                    w_state_n = W_DATA;
                end
            end
            W_DATA: begin
                if (w_fire) begin
                    // Our own beat count decides the end of the burst; a
                    // disagreeing wlast only poisons the response.
                    w_err_n = w_err | (wlast != w_is_last);
                    if (w_is_last) begin
                        wready_n  = 1'b0;
                        bvalid_n  = 1'b1;
                        bid_n     = w_id;
                        bresp_n   = w_err_n ? RESP_SLVERR : RESP_OKAY;
                        w_state_n = W_RESP;
                    end else begin
                        w_cnt_n  = w_cnt + 8'd1;
                        w_addr_n = next_addr(w_addr, w_size, w_burst);
                    end
                end
            end
            W_RESP: begin
                if (bvalid && bready) begin
                    bvalid_n  = 1'b0;
                    awready_n = 1'b1;
                    w_state_n = W_IDLE;
                end
            end
            default: w_state_n = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_state <= W_IDLE;
            w_addr  <= '0;
            w_cnt   <= '0;
            w_len   <= '0;
            w_size  <= '0;
            w_burst <= '0;
            w_id    <= '0;
            w_err   <= 1'b0;
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            bid     <= '0;
            bresp   <= '0;
        end else begin
            w_state <= w_state_n;
            w_addr  <= w_addr_n;
            w_cnt   <= w_cnt_n;
            w_len   <= w_len_n;
            w_size  <= w_size_n;
            w_burst <= w_burst_n;
            w_id    <= w_id_n;
            w_err   <= w_err_n;
            awready <= awready_n;
            wready  <= wready_n;
            bvalid  <= bvalid_n;
            bid     <= bid_n;
            bresp   <= bresp_n;
        end
    end

    // Storage has no reset; the write enable is gated by the FSM state, so an
    // asserted reset blocks any further writes.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb[i]) mem[w_addr[ADDR_BITS-1:2]][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Bench for axi_sram_slave: directed scenarios plus randomized bursts, all
// read data checked against a byte-level memory model kept here.
module tb_axi_sram_slave;
    localparam int ADDR_BITS = 16;
    localparam int WORDS     = 1 << (ADDR_BITS - 2);

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    axi_sram_slave #(.ADDR_BITS(ADDR_BITS), .INIT_FILE("")) dut (
        .clk(clk), .reset(reset),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
        .wready(wready), .bid(bid), .bresp(bresp), .bvalid(bvalid),
        .bready(bready)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Model: one entry per byte ever written, keyed by word*4+lane.
    byte unsigned model_b [int unsigned];
    logic [31:0]  wq_data [256];
    logic [3:0]   wq_strb [256];
    bit           rr_pat  [$];

    function automatic logic [31:0] beat_addr(input logic [31:0] start, input int k,
                                              input logic [2:0] size, input logic [1:0] burst);
        if (burst == 2'b01) return start + 32'(k) * (32'd1 << size);
        return start;
    endfunction

    function automatic int unsigned key(input logic [31:0] a, input int lane);
        logic [31:0] w;
        w = (a >> 2) & 32'(WORDS - 1);
        return w * 4 + 32'(lane);
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        for (int l = 0; l < 4; l++)
            if (s[l]) model_b[key(a, l)] = d[8*l +: 8];
    endtask

    task automatic model_read(input logic [31:0] a, output logic [31:0] d, output logic [31:0] m);
        d = '0;
        m = '0;
        for (int l = 0; l < 4; l++)
            if (model_b.exists(key(a, l))) begin
                d[8*l +: 8] = model_b[key(a, l)];
                m[8*l +: 8] = 8'hFF;
            end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Only bytes the model knows are compared.
    task automatic check_m(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp, input logic [31:0] m);
        if (m != 0) check(tag, obs & m, exp & m);
    endtask

    // Write burst; data/strobes come from wq_data/wq_strb. wlast is driven on
    // beat wlast_at only. Starts and ends on a falling edge.
    task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                             input logic [2:0] size, input logic [1:0] burst,
                             input int wlast_at, input bit gaps);
        int t;
        logic [1:0] exp_resp;
        exp_resp = (wlast_at != len || burst[1]) ? 2'b10 : 2'b00;
        check("wready_idle", 32'(wready), 32'd0);
        awid = id; awaddr = addr; awlen = 8'(len); awsize = size; awburst = burst;
        awvalid = 1'b1;
        t = 0;
        while (!awready && t < 100) begin @(negedge clk); t++; end
        check("aw_handshake", 32'(t < 100), 32'd1);
        @(negedge clk);
        awvalid = 1'b0;
        check("wready_after_aw", 32'(wready), 32'd1);
        check("awready_busy", 32'(awready), 32'd0);
        for (int k = 0; k <= len; k++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                wvalid = 1'b0;
                @(negedge clk);
            end
            wvalid = 1'b1; wdata = wq_data[k]; wstrb = wq_strb[k]; wlast = (k == wlast_at);
            t = 0;
            while (!wready && t < 100) begin @(negedge clk); t++; end
            check("w_handshake", 32'(t < 100), 32'd1);
            @(negedge clk);
            if (!burst[1]) model_write(beat_addr(addr, k, size, burst), wq_data[k], wq_strb[k]);
        end
        wvalid = 1'b0; wlast = 1'b0;
        check("wready_after_last", 32'(wready), 32'd0);
        if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
        bready = 1'b1;
        t = 0;
        while (!bvalid && t < 100) begin @(negedge clk); t++; end
        check("b_valid", 32'(bvalid), 32'd1);
        check("bid", 32'(bid), 32'(id));
        check("bresp", 32'(bresp), 32'(exp_resp));
        @(negedge clk);
        bready = 1'b0;
        check("bvalid_done", 32'(bvalid), 32'd0);
        check("awready_done", 32'(awready), 32'd1);
    endtask

    // Read burst. mode 0: rready always 1; 1: random; 2: rr_pat then 1.
    task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                            input logic [2:0] size, input logic [1:0] burst, input int mode);
        int t, k, cyc;
        bit rr;
        logic [31:0] ed, em;
        arid = id; araddr = addr; arlen = 8'(len); arsize = size; arburst = burst;
        arvalid = 1'b1;
        t = 0;
        while (!arready && t < 100) begin @(negedge clk); t++; end
        check("ar_handshake", 32'(t < 100), 32'd1);
        @(negedge clk);
        arvalid = 1'b0;
        check("rvalid_latency", 32'(rvalid), 32'd1);
        check("arready_busy", 32'(arready), 32'd0);
        k = 0; cyc = 0;
        while (k <= len && cyc < 3000) begin
            if (mode == 0)      rr = 1'b1;
            else if (mode == 1) rr = 1'($urandom_range(0, 1));
            else                rr = (cyc < rr_pat.size()) ? rr_pat[cyc] : 1'b1;
            rready = rr;
            check("rvalid_streaming", 32'(rvalid), 32'd1);
            model_read(beat_addr(addr, k, size, burst), ed, em);
            check_m("rdata", rdata, ed, em);
            check("rlast", 32'(rlast), 32'(k == len));
            check("rresp", 32'(rresp), burst[1] ? 32'd2 : 32'd0);
            check("rid", 32'(rid), 32'(id));
            if (rr && rvalid) k++;
            @(negedge clk);
            cyc++;
        end
        rready = 1'b0;
        check("r_beat_count", 32'(k), 32'(len + 1));
        check("rvalid_done", 32'(rvalid), 32'd0);
        check("arready_done", 32'(arready), 32'd1);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] ed, em;
        int t;
        reset = 1'b1;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
        rready = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_arready", 32'(arready), 32'd0);
        check("rst_awready", 32'(awready), 32'd0);
        check("rst_wready", 32'(wready), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_bvalid", 32'(bvalid), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_rmisc", {24'd0, rid, rresp, rlast, 1'b0}, 32'd0);
        check("rst_bmisc", {26'd0, bid, bresp}, 32'd0);
        reset = 1'b0;
        #1 check("arready_before_edge", 32'(arready), 32'd0);
        @(negedge clk);
        check("arready_after_reset", 32'(arready), 32'd1);
        check("awready_after_reset", 32'(awready), 32'd1);

        // Single-beat read of a known word
        wq_data[0] = 32'h11223344; wq_strb[0] = 4'hF;
        axi_write(4'h1, 32'h40, 0, 3'd2, 2'b01, 0, 0);
        axi_read(4'h9, 32'h40, 0, 3'd2, 2'b01, 0);

        // 4-beat INCR write then read back
        for (int k = 0; k < 4; k++) begin wq_data[k] = 32'hA0 + 32'(k); wq_strb[k] = 4'hF; end
        axi_write(4'h5, 32'h100, 3, 3'd2, 2'b01, 3, 0);
        axi_read(4'h2, 32'h100, 3, 3'd2, 2'b01, 0);
        model_read(32'h10C, ed, em);
        check("model_a3", ed, 32'hA3);

        // Partial strobes
        wq_data[0] = 32'h0; wq_strb[0] = 4'hF;
        axi_write(4'h0, 32'h0, 0, 3'd2, 2'b01, 0, 0);
        wq_data[0] = 32'hDEADBEEF; wq_strb[0] = 4'b0101;
        axi_write(4'h0, 32'h0, 0, 3'd2, 2'b01, 0, 0);
        model_read(32'h0, ed, em);
        check("strobe_model", ed, 32'h00AD00EF);
        axi_read(4'h3, 32'h0, 0, 3'd2, 2'b01, 0);

        // Backpressure pattern on R
        rr_pat = '{1, 0, 0, 1, 1, 0, 1};
        axi_read(4'h4, 32'h100, 3, 3'd2, 2'b01, 2);

        // wlast early -> SLVERR, data still written
        wq_data[0] = 32'h55AA0001; wq_data[1] = 32'h55AA0002; wq_strb[0] = 4'hF; wq_strb[1] = 4'hF;
        axi_write(4'h6, 32'h200, 1, 3'd2, 2'b01, 0, 0);
        axi_read(4'h6, 32'h200, 1, 3'd2, 2'b01, 0);
        // Reserved burst read -> 2 beats SLVERR at a fixed address
        axi_read(4'h7, 32'h200, 1, 3'd2, 2'b11, 0);
        // WRAP write -> SLVERR, memory untouched
        wq_data[0] = 32'hBAD0BAD0; wq_data[1] = 32'hBAD1BAD1;
        axi_write(4'h8, 32'h200, 1, 3'd2, 2'b10, 1, 0);
        axi_read(4'h8, 32'h200, 1, 3'd2, 2'b01, 0);

        // Concurrent independent read and write
        for (int k = 0; k < 6; k++) begin wq_data[k] = $urandom(); wq_strb[k] = 4'hF; end
        fork
            axi_write(4'hA, 32'h2000, 5, 3'd2, 2'b01, 5, 1);
            axi_read(4'hB, 32'h100, 3, 3'd2, 2'b01, 1);
        join
        axi_read(4'hC, 32'h2000, 5, 3'd2, 2'b01, 1);

        // Reset in the middle of an 8-beat read
        for (int k = 0; k < 8; k++) begin wq_data[k] = $urandom(); wq_strb[k] = 4'hF; end
        axi_write(4'h3, 32'h400, 7, 3'd2, 2'b01, 7, 0);
        arid = 4'h1; araddr = 32'h400; arlen = 8'd7; arsize = 3'd2; arburst = 2'b01;
        arvalid = 1'b1;
        t = 0;
        while (!arready && t < 100) begin @(negedge clk); t++; end
        check("rst_ar_handshake", 32'(t < 100), 32'd1);
        @(negedge clk);
        arvalid = 1'b0;
        rready = 1'b1;
        repeat (2) @(negedge clk);
        model_read(32'h408, ed, em);
        check_m("beat2_before_reset", rdata, ed, em);
        rready = 1'b0;
        reset = 1'b1;
        #1;
        check("rvalid_on_reset", 32'(rvalid), 32'd0);
        check("arready_on_reset", 32'(arready), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("arready_after_midreset", 32'(arready), 32'd1);
        check("rvalid_after_midreset", 32'(rvalid), 32'd0);
        axi_read(4'h2, 32'h400, 7, 3'd2, 2'b01, 0);

        // Randomized bursts, including narrow sizes, FIXED and aliased addresses
        for (int it = 0; it < 16; it++) begin
            logic [31:0] a;
            int len, r;
            logic [2:0] sz;
            logic [1:0] bt;
            a   = ($urandom() & 32'hFFFF0000) | 32'($urandom_range(0, 2047));
            len = $urandom_range(0, 15);
            sz  = 3'($urandom_range(0, 2));
            r   = $urandom_range(0, 9);
            bt  = (r < 6) ? 2'b01 : (r < 9) ? 2'b00 : 2'b11;
            for (int k = 0; k <= len; k++) begin
                wq_data[k] = $urandom();
                wq_strb[k] = 4'($urandom_range(0, 15));
            end
            axi_write(4'($urandom_range(0, 15)), a, len, sz, bt, len, 1);
            axi_read(4'($urandom_range(0, 15)), a & 32'h0000FFFF, len, sz, bt, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
